// File: rtl/sot_align_controller_if.sv
// sot_align_controller_if
//   Bundles the signals exchanged between the SoT alignment controller and
//   the bank of per-VFAT frame aligners.
//   Signals (width MXVFATS each):
//     aligned       aligner -> controller  sot_is_aligned per channel
//     unstable      aligner -> controller  sot_unstable per channel
//     aligner_reset controller -> aligner  per-channel aligner reset
//     aligner_mask  controller -> aligner  effective channel mask
//   Modports: master = controller side, slave = aligner-bank side.
interface sot_align_controller_if #(
  parameter int MXVFATS = 24
);
  logic [MXVFATS-1:0] aligned;
  logic [MXVFATS-1:0] unstable;
  logic [MXVFATS-1:0] aligner_reset;
  logic [MXVFATS-1:0] aligner_mask;

  modport master (
    input  aligned,
    input  unstable,
    output aligner_reset,
    output aligner_mask
  );

  modport slave (
    output aligned,
    output unstable,
    input  aligner_reset,
    input  aligner_mask
  );
endinterface

// File: rtl/sot_align_controller.sv
// sot_align_controller
//   Sequences start-of-frame alignment for all per-VFAT frame aligners:
//   resets the aligners, waits for every unmasked channel to lock, retries
//   channels that did not lock and finally marks them failed and masks them.
//   In READY it tracks lock loss (sticky) and counts instability events.
//   Ports:
//     clock, reset        fabric clock, synchronous active-high reset
//     resync_i            single-cycle request for a full realignment
//     vfat_mask_i         static user mask (1 = ignore channel)
//     timeout_i           WAIT timeout in clocks, 0 = never time out
//     aligner_if          master modport: aligned/unstable in,
//                         aligner_reset/aligner_mask out (both registered)
//     all_ready_o         high in READY
//     state_o             IDLE=0 RST=1 WAIT=2 RETRY=3 READY=4
//     retry_cnt_o         retries used in the current attempt
//     failed_o            channels that exhausted their retries
//     lost_o              sticky per-channel lock loss seen in READY
//     unstable_cnt_o      saturating count of instability events
module sot_align_controller #(
  parameter int MXVFATS      = 24,
  parameter int RST_CYCLES   = 4,
  parameter int GUARD_CYCLES = 4,
  parameter int RETRY_MAX    = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       resync_i,
  input  logic [MXVFATS-1:0]         vfat_mask_i,
  input  logic [15:0]                timeout_i,
  sot_align_controller_if.master     aligner_if,
  output logic                       all_ready_o,
  output logic [2:0]                 state_o,
  output logic [3:0]                 retry_cnt_o,
  output logic [MXVFATS-1:0]         failed_o,
  output logic [MXVFATS-1:0]         lost_o,
  output logic [15:0]                unstable_cnt_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RST   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RETRY = 3'd3,
    ST_READY = 3'd4
  } state_t;

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_t             state_q, state_d;
  logic [MXVFATS-1:0] target_q, target_d;
  logic [RCW-1:0]     rst_cnt_q, rst_cnt_d;
  logic [15:0]        wait_cnt_q, wait_cnt_d;
  logic [3:0]         retry_q, retry_d;
  logic [MXVFATS-1:0] failed_q, failed_d;
  logic [MXVFATS-1:0] lost_q, lost_d;
  logic [MXVFATS-1:0] mask_q, mask_d;
  logic [MXVFATS-1:0] areset_q, areset_d;
  logic [15:0]        ucnt_q, ucnt_d;
  logic [MXVFATS-1:0] aligned_prev_q;
  logic               unst_prev_q;

  logic               in_guard;
  logic [MXVFATS-1:0] done;
  logic               timeout_hit;
  logic               unst_any;
  logic               unst_rise;
  logic [MXVFATS-1:0] lost_set;

  // During the guard window only the mask counts as "done", so a fully
  // masked set cannot leave WAIT before the guard has elapsed.
  assign in_guard    = (state_q == ST_WAIT) && (wait_cnt_q < 16'(GUARD_CYCLES));
  assign done        = in_guard ? mask_q : (aligner_if.aligned | mask_q);
  assign timeout_hit = (timeout_i != 16'd0) && (wait_cnt_q == timeout_i);
  assign unst_any    = |(aligner_if.unstable & ~mask_q);
  assign unst_rise   = unst_any & ~unst_prev_q;

  // Falling edge of aligned on an unmasked channel.
  generate
    for (genvar gi = 0; gi < MXVFATS; gi++) begin : g_lost
      assign lost_set[gi] = aligned_prev_q[gi] & ~aligner_if.aligned[gi] & ~mask_q[gi];
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    rst_cnt_d  = rst_cnt_q;
    wait_cnt_d = wait_cnt_q;
    retry_d    = retry_q;
    failed_d   = failed_q;
    lost_d     = lost_q;
    ucnt_d     = ucnt_q;

    case (state_q)
      ST_IDLE: begin
        state_d   = ST_RST;
        target_d  = '1;
        retry_d   = 4'd0;
        rst_cnt_d = '0;
      end
      ST_RST: begin
        if (rst_cnt_q == RCW'(RST_CYCLES - 1)) begin
          state_d    = ST_WAIT;
          wait_cnt_d = 16'd0;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q != 16'hFFFF) begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
        // Full lock wins over a timeout landing in the same cycle.
        if (!in_guard && (&done)) begin
          state_d = ST_READY;
        end else if (timeout_hit) begin
          if (retry_q < 4'(RETRY_MAX)) begin
            state_d  = ST_RETRY;
            target_d = ~done;
          end else begin
            state_d  = ST_READY;
            failed_d = failed_q | ~done;
          end
        end
      end
      ST_RETRY: begin
        retry_d   = retry_q + 4'd1;
        rst_cnt_d = '0;
        state_d   = ST_RST;
      end
      ST_READY: begin
        lost_d = lost_q | lost_set;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (unst_rise && (state_q != ST_RST) && !in_guard && (ucnt_q != 16'hFFFF)) begin
      ucnt_d = ucnt_q + 16'd1;
    end

    // Resync restarts the whole sequence from any active state.
    if (resync_i && (state_q != ST_IDLE)) begin
      state_d   = ST_RST;
      target_d  = '1;
      rst_cnt_d = '0;
      retry_d   = 4'd0;
      failed_d  = '0;
      lost_d    = '0;
    end
  end

  // Mask follows failed_q, so a newly failed channel is masked one cycle later.
  assign mask_d   = vfat_mask_i | failed_q;
  // Registered so the pulse lines up exactly with the cycles spent in RST.
  assign areset_d = (state_d == ST_RST) ? target_d : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      target_q       <= '0;
      rst_cnt_q      <= '0;
      wait_cnt_q     <= 16'd0;
      retry_q        <= 4'd0;
      failed_q       <= '0;
      lost_q         <= '0;
      mask_q         <= '0;
      areset_q       <= '1;
      ucnt_q         <= 16'd0;
      aligned_prev_q <= '0;
      unst_prev_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      target_q       <= target_d;
      rst_cnt_q      <= rst_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      retry_q        <= retry_d;
      failed_q       <= failed_d;
      lost_q         <= lost_d;
      mask_q         <= mask_d;
      areset_q       <= areset_d;
      ucnt_q         <= ucnt_d;
      aligned_prev_q <= aligner_if.aligned;
      unst_prev_q    <= unst_any;
    end
  end

  assign aligner_if.aligner_reset = areset_q;
  assign aligner_if.aligner_mask  = mask_q;
  assign all_ready_o              = (state_q == ST_READY);
  assign state_o                  = state_q;
  assign retry_cnt_o              = retry_q;
  assign failed_o                 = failed_q;
  assign lost_o                   = lost_q;
  assign unstable_cnt_o           = ucnt_q;

endmodule

// File: tb/tb_sot_align_controller.sv
// tb_sot_align_controller
//   Directed bench for sot_align_controller with MXVFATS=4.
module tb_sot_align_controller;

  localparam int N = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         resync_i;
  logic [N-1:0] vfat_mask_i;
  logic [15:0]  timeout_i;
  logic         all_ready_o;
  logic [2:0]   state_o;
  logic [3:0]   retry_cnt_o;
  logic [N-1:0] failed_o;
  logic [N-1:0] lost_o;
  logic [15:0]  unstable_cnt_o;

  int checks   = 0;
  int failures = 0;

  sot_align_controller_if #(.MXVFATS(N)) al_if ();

  sot_align_controller #(
    .MXVFATS(N), .RST_CYCLES(4), .GUARD_CYCLES(4), .RETRY_MAX(3)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .resync_i       (resync_i),
    .vfat_mask_i    (vfat_mask_i),
    .timeout_i      (timeout_i),
    .aligner_if     (al_if.master),
    .all_ready_o    (all_ready_o),
    .state_o        (state_o),
    .retry_cnt_o    (retry_cnt_o),
    .failed_o       (failed_o),
    .lost_o         (lost_o),
    .unstable_cnt_o (unstable_cnt_o)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: got=%0h", tag, got);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output bit found);
    found = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (state_o == s) begin
        found = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic unstable_burst(input logic [N-1:0] pat);
    al_if.unstable = pat;   tick();
    al_if.unstable = '0;    tick();
    al_if.unstable = pat;   tick();
    al_if.unstable = '0;    tick();
  endtask

  initial begin
    bit found;
    int n_full;
    int n_b8;
    int first_ready;

    // ---------------- reset state ----------------
    reset = 1'b1; resync_i = 1'b0; vfat_mask_i = '0; timeout_i = 16'd100;
    al_if.aligned = '0; al_if.unstable = '0;
    repeat (3) tick();
    check_eq("rst_state", 32'(state_o), 32'd0);
    check_eq("rst_all_ready", 32'(all_ready_o), 32'd0);
    check_eq("rst_aligner_reset", 32'(al_if.aligner_reset), 32'hF);
    check_eq("rst_mask", 32'(al_if.aligner_mask), 32'd0);
    check_eq("rst_retry", 32'(retry_cnt_o), 32'd0);
    check_eq("rst_failed", 32'(failed_o), 32'd0);
    check_eq("rst_unstable_cnt", 32'(unstable_cnt_o), 32'd0);

    // ---------------- normal alignment ----------------
    reset = 1'b0;
    tick();
    n_full = 0;
    for (int k = 0; k < 20 && state_o == 3'd1; k++) begin
      if (al_if.aligner_reset == 4'hF) n_full++;
      tick();
    end
    check_eq("t1_rst_pulse_len", 32'(n_full), 32'd4);
    check_eq("t1_state_wait", 32'(state_o), 32'd2);
    check_eq("t1_reset_released", 32'(al_if.aligner_reset), 32'd0);
    repeat (10) tick();
    check_eq("t1_still_wait", 32'(state_o), 32'd2);
    al_if.aligned = 4'hF;
    wait_state(3'd4, 20, found);
    check_eq("t1_ready_reached", 32'(found), 32'd1);
    check_eq("t1_all_ready", 32'(all_ready_o), 32'd1);
    check_eq("t1_retry", 32'(retry_cnt_o), 32'd0);
    check_eq("t1_failed", 32'(failed_o), 32'd0);

    // ---------------- lock loss and resync ----------------
    al_if.aligned = 4'hB; tick();
    al_if.aligned = 4'hF; tick();
    check_eq("t4_lost", 32'(lost_o), 32'h4);
    check_eq("t4_all_ready_kept", 32'(all_ready_o), 32'd1);
    tick();
    check_eq("t4_lost_sticky", 32'(lost_o), 32'h4);
    resync_i = 1'b1; tick(); resync_i = 1'b0;
    check_eq("t4_resync_state", 32'(state_o), 32'd1);
    check_eq("t4_resync_lost_clr", 32'(lost_o), 32'd0);
    check_eq("t4_resync_full_rst", 32'(al_if.aligner_reset), 32'hF);
    wait_state(3'd4, 40, found);
    check_eq("t4_ready_again", 32'(found), 32'd1);

    // ---------------- instability counter ----------------
    check_eq("t5_cnt_start", 32'(unstable_cnt_o), 32'd0);
    unstable_burst(4'b0010);
    check_eq("t5_cnt_two", 32'(unstable_cnt_o), 32'd2);
    vfat_mask_i = 4'b0010; tick(); tick();
    check_eq("t5_mask_applied", 32'(al_if.aligner_mask), 32'h2);
    unstable_burst(4'b0010);
    check_eq("t5_masked_no_inc", 32'(unstable_cnt_o), 32'd2);
    check_eq("t5_still_ready", 32'(state_o), 32'd4);
    vfat_mask_i = '0; tick();

    // ---------------- guard window ----------------
    reset = 1'b1; timeout_i = 16'd100; al_if.aligned = 4'hF;
    tick(); tick();
    check_eq("t3_rst_cnt_cleared", 32'(unstable_cnt_o), 32'd0);
    reset = 1'b0;
    tick();
    first_ready = -1;
    for (int k = 0; k < 30; k++) begin
      if (state_o == 3'd4 && first_ready < 0) first_ready = k;
      tick();
    end
    check_eq("t3_first_ready_cycle", 32'(first_ready), 32'd9);

    // ---------------- retries and failure ----------------
    reset = 1'b1; timeout_i = 16'd20; al_if.aligned = 4'b0111;
    tick(); tick();
    reset = 1'b0;
    tick();
    n_full = 0; n_b8 = 0; found = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if (state_o == 3'd4) begin
        found = 1'b1;
        break;
      end
      if (state_o == 3'd1 && al_if.aligner_reset == 4'hF) n_full++;
      if (state_o == 3'd1 && al_if.aligner_reset == 4'h8) n_b8++;
      tick();
    end
    check_eq("t2_ready_reached", 32'(found), 32'd1);
    check_eq("t2_full_rst_cycles", 32'(n_full), 32'd4);
    check_eq("t2_retry_rst_cycles", 32'(n_b8), 32'd12);
    check_eq("t2_retry_cnt", 32'(retry_cnt_o), 32'd3);
    check_eq("t2_failed", 32'(failed_o), 32'h8);
    check_eq("t2_all_ready", 32'(all_ready_o), 32'd1);
    tick();
    check_eq("t2_mask", 32'(al_if.aligner_mask), 32'h8);

    // ---------------- no timeout, then mid-WAIT reset ----------------
    reset = 1'b1; timeout_i = 16'd0; al_if.aligned = 4'b0011;
    tick(); tick();
    reset = 1'b0;
    repeat (300) tick();
    check_eq("t6_wait_forever", 32'(state_o), 32'd2);
    check_eq("t6_no_retry", 32'(retry_cnt_o), 32'd0);
    check_eq("t6_no_failed", 32'(failed_o), 32'd0);
    check_eq("t6_not_ready", 32'(all_ready_o), 32'd0);
    al_if.unstable = 4'b0001; tick(); al_if.unstable = '0;
    check_eq("t6_unstable_in_wait", 32'(unstable_cnt_o), 32'd1);
    reset = 1'b1; tick();
    check_eq("t6_reset_state", 32'(state_o), 32'd0);
    check_eq("t6_reset_cnt", 32'(unstable_cnt_o), 32'd0);
    check_eq("t6_reset_areset", 32'(al_if.aligner_reset), 32'hF);
    check_eq("t6_reset_mask", 32'(al_if.aligner_mask), 32'd0);
    reset = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
